// File: rtl/pipe_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake and a one-entry skid buffer.
// The skid entry absorbs the word that arrives on the cycle a stall begins, so in_ready can be registered.
module pipe_skid_reg #(
    parameter int                 WIDTH       = 32,
    parameter logic [WIDTH-1:0]   BUBBLE_DATA = '0,
    parameter int                 CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cycles
);

    // Encoding equals the number of held words, so occupancy is the state itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   main_data;
    logic [WIDTH-1:0]   skid_data;
    logic               main_valid;
    logic               skid_valid;
    logic               in_xfer;
    logic               out_xfer;
    logic               load_main_in;
    logic               load_main_skid;
    logic               load_skid;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        in_xfer        = in_valid && in_ready && !flush;
        out_xfer       = out_valid && out_ready;
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    state_next   = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                case ({out_xfer, in_xfer})
                    2'b11:   load_main_in = 1'b1;
                    2'b10:   state_next   = EMPTY;
                    2'b01: begin
                        state_next = FULL;
                        load_skid  = 1'b1;
                    end
                    default: state_next   = ONE;
                endcase
            end
            FULL: begin
                if (out_xfer) begin
                    state_next     = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
        // A redirect squashes everything held, including a word offered this cycle.
        if (flush) begin
            state_next = EMPTY;
        end
    end

    always_comb begin
        main_valid = (state != EMPTY);
        skid_valid = (state == FULL);
        in_ready   = !skid_valid;
        out_valid  = main_valid;
        out_data   = main_valid ? main_data : BUBBLE_DATA;
        occupancy  = state;
    end

    // NOTE: payload registers carry no reset; their contents are never visible without a valid.
    always_ff @(posedge clk) begin
        if (load_main_in) begin
            main_data <= in_data;
        end else if (load_main_skid) begin
            main_data <= skid_data;
        end
        if (load_skid) begin
            skid_data <= in_data;
        end
    end

    // Saturating stall counter; survives flush so it reflects total back-pressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (out_valid && !out_ready && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenario tasks plus a scoreboard monitor
// that tracks every accepted word and checks it leaves in order.
module tb_pipe_skid_reg;

    localparam int           WIDTH  = 32;
    localparam logic [31:0]  BUBBLE = 32'hDEAD_0013;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic [WIDTH-1:0]  in_data = '0;
    logic              in_ready;
    logic              out_valid;
    logic [WIDTH-1:0]  out_data;
    logic              out_ready = 1'b1;
    logic [1:0]        occupancy;
    logic [15:0]       stall_cycles;

    logic              s_flush = 1'b0;
    logic              s_in_valid = 1'b0;
    logic [7:0]        s_in_data = '0;
    logic              s_in_ready;
    logic              s_out_valid;
    logic [7:0]        s_out_data;
    logic              s_out_ready = 1'b1;
    logic [1:0]        s_occ;
    logic [1:0]        s_stall;

    int checks = 0;
    int passed = 0;
    logic [WIDTH-1:0] sb[$];

    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(WIDTH), .BUBBLE_DATA(BUBBLE), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .occupancy(occupancy), .stall_cycles(stall_cycles)
    );

    pipe_skid_reg #(.WIDTH(8), .BUBBLE_DATA(8'h00), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .flush(s_flush),
        .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
        .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(s_out_ready),
        .occupancy(s_occ), .stall_cycles(s_stall)
    );

    // Monitor: samples mid-cycle, when the inputs for the coming edge are stable.
    always @(negedge clk) begin
        logic [WIDTH-1:0] exp;
        if (!rst) begin
            sb.delete();
        end else begin
            checks++;
            if (int'(occupancy) !== sb.size())
                $display("FAIL sb_occupancy: got %0d expected %0d", occupancy, sb.size());
            else passed++;
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_unexpected_word: got %h with nothing pending", out_data);
                end else begin
                    exp = sb.pop_front();
                    if (out_data !== exp)
                        $display("FAIL sb_order: got %h expected %h", out_data, exp);
                    else passed++;
                end
            end
            if (!out_valid) begin
                checks++;
                if (out_data !== BUBBLE)
                    $display("FAIL sb_bubble: got %h expected %h", out_data, BUBBLE);
                else passed++;
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back(in_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else passed++;
        checks++; if (out_data !== BUBBLE) $display("FAIL rst_out_data: got %h expected %h", out_data, BUBBLE); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", in_ready); else passed++;
        checks++; if (occupancy !== 2'd0) $display("FAIL rst_occupancy: got %0d expected 0", occupancy); else passed++;
        checks++; if (stall_cycles !== 16'd0) $display("FAIL rst_stall: got %0d expected 0", stall_cycles); else passed++;
        tick(); tick();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
            $display("FAIL rst_held: got valid=%b occ=%0d expected 0/0", out_valid, occupancy); else passed++;
        in_valid = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_streaming();
        logic [WIDTH-1:0] words [3];
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = words[i];
            checks++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready: got %b expected 1", in_ready); else passed++;
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== words[i])
                $display("FAIL stream_out: got valid=%b data=%h expected 1/%h", out_valid, out_data, words[i]); else passed++;
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL stream_drain: got %b expected 0", out_valid); else passed++;
    endtask

    task automatic test_skid();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hA1;
        tick();
        in_data = 32'hA2; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        checks++; if (occupancy !== 2'd2) $display("FAIL skid_occ: got %0d expected 2", occupancy); else passed++;
        checks++; if (in_ready !== 1'b0) $display("FAIL skid_in_ready: got %b expected 0", in_ready); else passed++;
        checks++; if (out_data !== 32'hA1) $display("FAIL skid_hold: got %h expected a1", out_data); else passed++;
        tick();
        checks++; if (out_data !== 32'hA1 || occupancy !== 2'd2)
            $display("FAIL skid_hold2: got %h occ=%0d expected a1/2", out_data, occupancy); else passed++;
        out_ready = 1'b1;
        tick();
        checks++; if (out_data !== 32'hA2 || occupancy !== 2'd1)
            $display("FAIL skid_second: got %h occ=%0d expected a2/1", out_data, occupancy); else passed++;
        tick();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
            $display("FAIL skid_empty: got valid=%b occ=%0d expected 0/0", out_valid, occupancy); else passed++;
        checks++; if (stall_cycles !== 16'd2) $display("FAIL skid_stall: got %0d expected 2", stall_cycles); else passed++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hC1;
        tick();
        in_data = 32'hC2;
        tick();
        checks++; if (occupancy !== 2'd2) $display("FAIL flush_fill: got %0d expected 2", occupancy); else passed++;
        flush = 1'b1; in_data = 32'hBB;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("FAIL flush_valid: got %b expected 0", out_valid); else passed++;
        checks++; if (occupancy !== 2'd0) $display("FAIL flush_occ: got %0d expected 0", occupancy); else passed++;
        checks++; if (out_data !== BUBBLE) $display("FAIL flush_data: got %h expected %h", out_data, BUBBLE); else passed++;
        checks++; if (stall_cycles !== 16'd4) $display("FAIL flush_stall_kept: got %0d expected 4", stall_cycles); else passed++;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0) $display("FAIL flush_no_bb: got valid=%b data=%h expected 0", out_valid, out_data); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hD1;
        tick();
        in_data = 32'hD2;
        tick();
        in_valid = 1'b0;
        checks++; if (occupancy !== 2'd2) $display("FAIL rmid_fill: got %0d expected 2", occupancy); else passed++;
        #2 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1)
            $display("FAIL rmid_async: got valid=%b occ=%0d rdy=%b expected 0/0/1", out_valid, occupancy, in_ready); else passed++;
        checks++; if (stall_cycles !== 16'd0) $display("FAIL rmid_stall: got %0d expected 0", stall_cycles); else passed++;
        tick();
        rst = 1'b1; in_valid = 1'b1; in_data = 32'h5A; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h5A || occupancy !== 2'd1)
            $display("FAIL rmid_5a: got valid=%b data=%h occ=%0d expected 1/5a/1", out_valid, out_data, occupancy); else passed++;
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL rmid_alone: got %b expected 0", out_valid); else passed++;
    endtask

    task automatic test_saturate();
        s_in_valid = 1'b1; s_in_data = 8'h3C; s_out_ready = 1'b0;
        tick();
        s_in_valid = 1'b0;
        checks++; if (s_stall !== 2'd0) $display("FAIL sat_start: got %0d expected 0", s_stall); else passed++;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++; if (s_stall !== ((k < 3) ? 2'(k) : 2'd3))
                $display("FAIL sat_count_%0d: got %0d expected %0d", k, s_stall, (k < 3) ? k : 3); else passed++;
        end
        checks++; if (s_out_data !== 8'h3C || s_occ !== 2'd1)
            $display("FAIL sat_hold: got %h occ=%0d expected 3c/1", s_out_data, s_occ); else passed++;
        s_out_ready = 1'b1;
        tick();
        checks++; if (s_out_valid !== 1'b0 || s_out_data !== 8'h00 || s_stall !== 2'd3)
            $display("FAIL sat_release: got valid=%b data=%h stall=%0d expected 0/00/3", s_out_valid, s_out_data, s_stall); else passed++;
    endtask

    task automatic test_back_to_back();
        int budget;
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        budget = 0;
        while (occupancy != 2'd0 && budget < 10) begin
            tick();
            budget++;
        end
        tick();
        checks++; if (sb.size() != 0 || out_valid !== 1'b0)
            $display("FAIL b2b_drain: got pending=%0d valid=%b expected 0/0", sb.size(), out_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_skid();
        test_flush();
        test_reset_mid();
        test_saturate();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
